// File: rtl/risc_vector_boot_loader.sv
// risc_vector_boot_loader
// Preload engine for the risc_vector core. Parses a framed byte stream
// (HDR, CNT, ADDR, data bytes MSB first, CHK) and turns it into one-hot
// word writes on NUM_MEMS memory ports. The core is held in reset until an
// end-of-load marker (HDR = 8'hFF) is seen; a bad header or checksum parks
// the engine in a sticky error state with the core still in reset.

module risc_vector_boot_loader #(
    parameter int MEM_DATA_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int NUM_MEMS       = 3
) (
    input  logic                      Clk_i,
    input  logic                      Rst_n_i,
    input  logic                      Load_valid_i,
    input  logic [7:0]                Load_data_i,
    output logic                      Load_ready_o,
    output logic [NUM_MEMS-1:0]       Mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0] Mem_addr_o,
    output logic [MEM_DATA_WIDTH-1:0] Mem_wdata_o,
    output logic                      Core_rst_n_o,
    output logic                      Done_o,
    output logic                      Err_o
);

    localparam int BPW = MEM_DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_CNT,
        ST_ADDR,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    state_e                      state_q;
    logic [2:0]                  sel_q;
    logic [7:0]                  cnt_q;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q;
    logic [MEM_DATA_WIDTH-1:0]   word_q;
    logic [7:0]                  byteIdx_q;
    logic [7:0]                  chk_q;
    logic [NUM_MEMS-1:0]         we_q;
    logic [MEM_ADDR_WIDTH-1:0]   memAddr_q;
    logic [MEM_DATA_WIDTH-1:0]   wdata_q;
    logic                        ready_q;
    logic                        coreRstN_q;
    logic                        done_q;
    logic                        err_q;

    logic                        accept;
    logic [MEM_DATA_WIDTH-1:0]   word_d;
    logic [7:0]                  chk_d;
    logic [NUM_MEMS-1:0]         selHot;

    assign accept = Load_valid_i & ready_q;

    // Next word value (incoming byte shifted in at the bottom) and running checksum.
    always_comb begin
        word_d = (word_q << 8) | MEM_DATA_WIDTH'(Load_data_i);
        chk_d  = chk_q ^ Load_data_i;
    end

    // One-hot write strobe pattern for the memory selected by the current frame.
    always_comb begin
        selHot = '0;
        for (int m = 0; m < NUM_MEMS; m++) begin
            if (int'(sel_q) == m) begin
                selHot[m] = 1'b1;
            end
        end
    end

    // Frame parser: advances one step per accepted byte and registers all outputs.
    always_ff @(posedge Clk_i or negedge Rst_n_i) begin
        if (!Rst_n_i) begin
            state_q    <= ST_HDR;
            sel_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            word_q     <= '0;
            byteIdx_q  <= '0;
            chk_q      <= '0;
            we_q       <= '0;
            memAddr_q  <= '0;
            wdata_q    <= '0;
            ready_q    <= 1'b1;
            coreRstN_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q <= '0;
            if (accept) begin
                case (state_q)
                    ST_HDR: begin
                        if (Load_data_i == 8'hFF) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            coreRstN_q <= 1'b1;
                            ready_q    <= 1'b0;
                        end else if (Load_data_i >= 8'(NUM_MEMS)) begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            sel_q   <= Load_data_i[2:0];
                            chk_q   <= Load_data_i;
                            state_q <= ST_CNT;
                        end
                    end
                    ST_CNT: begin
                        cnt_q   <= Load_data_i;
                        chk_q   <= chk_d;
                        state_q <= ST_ADDR;
                    end
                    ST_ADDR: begin
                        addr_q    <= Load_data_i[MEM_ADDR_WIDTH-1:0];
                        chk_q     <= chk_d;
                        byteIdx_q <= '0;
                        word_q    <= '0;
                        state_q   <= ST_DATA;
                    end
                    ST_DATA: begin
                        chk_q  <= chk_d;
                        word_q <= word_d;
                        if (byteIdx_q == 8'(BPW - 1)) begin
                            byteIdx_q <= '0;
                            we_q      <= selHot;
                            memAddr_q <= addr_q;
                            wdata_q   <= word_d;
                            addr_q    <= addr_q + MEM_ADDR_WIDTH'(1);
                            if (cnt_q == 8'd0) begin
                                state_q <= ST_CHK;
                            end else begin
                                cnt_q <= cnt_q - 8'd1;
                            end
                        end else begin
                            byteIdx_q <= byteIdx_q + 8'd1;
                        end
                    end
                    ST_CHK: begin
                        if (Load_data_i == chk_q) begin
                            state_q <= ST_HDR;
                        end else begin
                            state_q <= ST_ERR;
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign Load_ready_o = ready_q;
    assign Mem_we_o     = we_q;
    assign Mem_addr_o   = memAddr_q;
    assign Mem_wdata_o  = wdata_q;
    assign Core_rst_n_o = coreRstN_q;
    assign Done_o       = done_q;
    assign Err_o        = err_q;

endmodule

// File: tb/tb_risc_vector_boot_loader.sv
// tb_risc_vector_boot_loader
// Scoreboard bench for the boot loader. Frames are described at word level
// (memory, start address, list of words); the bench encodes them into bytes,
// and every time it hands over a byte that completes a word it queues the
// write that must appear on the memory port one cycle later. A separate
// monitor pops that queue whenever a strobe is seen.

module tb_risc_vector_boot_loader;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int NM    = 3;
    localparam int DEPTH = 1 << AW;

    typedef struct {
        int          mem;
        int          addr;
        logic [15:0] data;
        int          cycle;
    } expWrite_t;

    logic          Clk_i = 1'b0;
    logic          Rst_n_i = 1'b1;
    logic          Load_valid_i = 1'b0;
    logic [7:0]    Load_data_i = 8'h00;
    logic          Load_ready_o;
    logic [NM-1:0] Mem_we_o;
    logic [AW-1:0] Mem_addr_o;
    logic [DW-1:0] Mem_wdata_o;
    logic          Core_rst_n_o;
    logic          Done_o;
    logic          Err_o;

    int            checks = 0;
    int            failures = 0;
    int            cycleCount = 0;
    expWrite_t     expQ[$];
    expWrite_t     monE;
    logic [15:0]   frameWords[$];

    risc_vector_boot_loader #(
        .MEM_DATA_WIDTH(DW),
        .MEM_ADDR_WIDTH(AW),
        .NUM_MEMS(NM)
    ) dut (
        .Clk_i(Clk_i),
        .Rst_n_i(Rst_n_i),
        .Load_valid_i(Load_valid_i),
        .Load_data_i(Load_data_i),
        .Load_ready_o(Load_ready_o),
        .Mem_we_o(Mem_we_o),
        .Mem_addr_o(Mem_addr_o),
        .Mem_wdata_o(Mem_wdata_o),
        .Core_rst_n_o(Core_rst_n_o),
        .Done_o(Done_o),
        .Err_o(Err_o)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 Clk_i = ~Clk_i;

    // Cycle counter used to timestamp accepted bytes and observed strobes.
    always @(posedge Clk_i) cycleCount <= cycleCount + 1;

    // Single comparison point: counts the check and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every strobe seen on the write port must match the oldest queued write.
    always @(negedge Clk_i) begin
        if (Rst_n_i === 1'b1 && Mem_we_o !== '0) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpectedStrobe actual we=%b addr=%0d data=%h required no write",
                         Mem_we_o, Mem_addr_o, Mem_wdata_o);
            end else begin
                monE = expQ.pop_front();
                checkOutput("strobeWe", 32'(Mem_we_o), 32'd1 << monE.mem);
                checkOutput("strobeAddr", 32'(Mem_addr_o), monE.addr);
                checkOutput("strobeData", 32'(Mem_wdata_o), 32'(monE.data));
                checkOutput("strobeCycle", cycleCount, monE.cycle);
            end
        end
    end

    // Offer one byte after 0..gapMax idle cycles; ok reports whether it was accepted.
    task automatic applyStimulus(input logic [7:0] b, input int gapMax, output bit ok);
        int gap;
        bit rdy;
        gap = (gapMax > 0) ? $urandom_range(gapMax, 0) : 0;
        Load_valid_i = 1'b0;
        repeat (gap) begin
            @(posedge Clk_i);
            #1;
        end
        Load_valid_i = 1'b1;
        Load_data_i  = b;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            rdy = Load_ready_o;
            @(posedge Clk_i);
            #1;
            if (rdy) ok = 1'b1;
        end
        Load_valid_i = 1'b0;
        if (!ok) begin
            checks++;
            failures++;
            $display("[TB] FAIL acceptTimeout actual=not accepted required=accepted byte=%h", b);
        end
    endtask

    // Encode frameWords as a frame for memory sel at addr and send it; stopAfter>=0 truncates.
    task automatic sendFrame(input int sel, input int addr, input int gapMax, input bit badChk,
                             input int stopAfter);
        logic [7:0] bytesQ[$];
        int         wordIdx[$];
        logic [7:0] chk;
        logic [15:0] w;
        int         cntV;
        bit         ok;
        expWrite_t  e;
        cntV = frameWords.size() - 1;
        bytesQ.push_back(sel[7:0]);  wordIdx.push_back(-1);
        bytesQ.push_back(cntV[7:0]); wordIdx.push_back(-1);
        bytesQ.push_back(addr[7:0]); wordIdx.push_back(-1);
        for (int i = 0; i < frameWords.size(); i++) begin
            w = frameWords[i];
            bytesQ.push_back(w[15:8]); wordIdx.push_back(-1);
            bytesQ.push_back(w[7:0]);  wordIdx.push_back(i);
        end
        chk = 8'h00;
        foreach (bytesQ[k]) chk = chk ^ bytesQ[k];
        bytesQ.push_back(badChk ? ~chk : chk);
        wordIdx.push_back(-1);
        for (int k = 0; k < bytesQ.size(); k++) begin
            if (stopAfter >= 0 && k >= stopAfter) break;
            applyStimulus(bytesQ[k], gapMax, ok);
            if (!ok) return;
            if (wordIdx[k] >= 0) begin
                e.mem   = sel;
                e.addr  = ((addr % DEPTH) + wordIdx[k]) % DEPTH;
                e.data  = frameWords[wordIdx[k]];
                e.cycle = cycleCount;
                expQ.push_back(e);
            end
        end
    endtask

    // End-of-load marker: core released and Done raised the cycle after it is accepted.
    task automatic sendEnd(input int gapMax);
        bit ok;
        checkOutput("coreRstBeforeEnd", 32'(Core_rst_n_o), 0);
        checkOutput("doneBeforeEnd", 32'(Done_o), 0);
        applyStimulus(8'hFF, gapMax, ok);
        checkOutput("doneAfterEnd", 32'(Done_o), 1);
        checkOutput("coreRstAfterEnd", 32'(Core_rst_n_o), 1);
        checkOutput("readyAfterEnd", 32'(Load_ready_o), 0);
        checkOutput("errAfterEnd", 32'(Err_o), 0);
    endtask

    // Let any pending strobe drain, then require the scoreboard to be empty.
    task automatic drain();
        repeat (3) begin
            @(posedge Clk_i);
            #1;
        end
        checkOutput("queueEmpty", expQ.size(), 0);
    endtask

    // Reset values while reset is held.
    task automatic checkResetState(input string tag);
        checkOutput({tag, "_we"}, 32'(Mem_we_o), 0);
        checkOutput({tag, "_addr"}, 32'(Mem_addr_o), 0);
        checkOutput({tag, "_wdata"}, 32'(Mem_wdata_o), 0);
        checkOutput({tag, "_ready"}, 32'(Load_ready_o), 1);
        checkOutput({tag, "_coreRst"}, 32'(Core_rst_n_o), 0);
        checkOutput({tag, "_done"}, 32'(Done_o), 0);
        checkOutput({tag, "_err"}, 32'(Err_o), 0);
    endtask

    // Pulse the asynchronous reset and release it just after a rising edge.
    task automatic doReset();
        Rst_n_i = 1'b0;
        #2;
        checkResetState("reset");
        @(posedge Clk_i);
        #1;
        Rst_n_i = 1'b1;
        @(posedge Clk_i);
        #1;
    endtask

    // Main sequence: directed frames, error cases, stalls, mid-frame reset, random frames.
    initial begin
        bit ok;
        int nFrames;
        #3;
        doReset();

        $display("[TB] test 1: two words into icmem");
        frameWords = '{16'h1234, 16'h5678};
        sendFrame(0, 8'h03, 0, 1'b0, -1);
        sendEnd(0);
        drain();

        $display("[TB] test 2: vdcmem with address wrap");
        doReset();
        frameWords = '{16'hAABB, 16'hCCDD};
        sendFrame(2, 8'h1F, 0, 1'b0, -1);
        sendEnd(0);
        drain();

        $display("[TB] test 3: bad checksum keeps write, flags error");
        doReset();
        frameWords = '{16'hBEEF};
        sendFrame(1, 8'h05, 0, 1'b1, -1);
        checkOutput("badChkErr", 32'(Err_o), 1);
        checkOutput("badChkReady", 32'(Load_ready_o), 0);
        checkOutput("badChkCoreRst", 32'(Core_rst_n_o), 0);
        checkOutput("badChkDone", 32'(Done_o), 0);
        drain();
        checkOutput("badChkErrSticky", 32'(Err_o), 1);

        $display("[TB] test 4: header selects missing memory");
        doReset();
        applyStimulus(8'h03, 0, ok);
        checkOutput("badHdrErr", 32'(Err_o), 1);
        checkOutput("badHdrReady", 32'(Load_ready_o), 0);
        checkOutput("badHdrCoreRst", 32'(Core_rst_n_o), 0);
        drain();

        $display("[TB] test 5: test 1 with idle gaps");
        doReset();
        frameWords = '{16'h1234, 16'h5678};
        sendFrame(0, 8'h03, 5, 1'b0, -1);
        sendEnd(5);
        drain();

        $display("[TB] test 6: reset mid-word, then replay");
        doReset();
        frameWords = '{16'h1234, 16'h5678};
        sendFrame(0, 8'h03, 0, 1'b0, 6);
        checkOutput("midFrameQueue", expQ.size(), 0);
        Rst_n_i = 1'b0;
        #1;
        checkResetState("midReset");
        @(posedge Clk_i);
        #1;
        Rst_n_i = 1'b1;
        repeat (2) begin
            @(posedge Clk_i);
            #1;
        end
        sendFrame(0, 8'h03, 2, 1'b0, -1);
        sendEnd(0);
        drain();

        $display("[TB] test 7: random frames");
        doReset();
        nFrames = $urandom_range(6, 3);
        for (int f = 0; f < nFrames; f++) begin
            frameWords.delete();
            for (int i = 0; i < $urandom_range(6, 1); i++) frameWords.push_back(16'($urandom));
            sendFrame($urandom_range(NM - 1, 0), $urandom_range(255, 0), 3, 1'b0, -1);
        end
        sendEnd(3);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so a stuck run still terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
